// File: rtl/ref_cache_pkg.sv
// rtl/ref_cache_pkg.sv - shared reference-cache widths, DRAM layout offsets and lookup record
package ref_cache_pkg;

    localparam int SET_ADDR_WDTH = 5;
    localparam int TAG_ADDR_WDTH = 10;
    localparam int C_N_WAY       = 4;
    localparam int REF_ADDR_WDTH = 4;

    // Byte strides of the reference-frame layout in DRAM
    localparam int BU_OFFSET     = 64;
    localparam int BU_ROW_OFFSET = 512;
    localparam int IU_OFFSET     = 4096;
    localparam int IU_ROW_OFFSET = 131072;
    localparam int FRAME_OFFSET  = 4194304;

    typedef struct packed {
        logic                     is_hit;
        logic [C_N_WAY-1:0]       set_idx;
        logic [SET_ADDR_WDTH-1:0] set_addr;
        logic [TAG_ADDR_WDTH-1:0] tag;
        logic [REF_ADDR_WDTH-1:0] ref_idx;
    } lookup_t;

endpackage

// File: rtl/ref_tag_compare_pipe_if.sv
// rtl/ref_tag_compare_pipe_if.sv - tag-lookup result handshake bus into the tag-compare stage
interface ref_tag_compare_pipe_if #(
    parameter int SET_ADDR_WDTH = ref_cache_pkg::SET_ADDR_WDTH,
    parameter int TAG_ADDR_WDTH = ref_cache_pkg::TAG_ADDR_WDTH,
    parameter int C_N_WAY       = ref_cache_pkg::C_N_WAY,
    parameter int REF_ADDR_WDTH = ref_cache_pkg::REF_ADDR_WDTH,
    parameter int X_CL_WDTH     = 9,
    parameter int Y_CL_WDTH     = 9,
    parameter int PAYLOAD_WDTH  = 64
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     in_is_hit;
    logic [C_N_WAY-1:0]       in_set_idx;
    logic [SET_ADDR_WDTH-1:0] in_set_addr;
    logic [TAG_ADDR_WDTH-1:0] in_tag_addr;
    logic [REF_ADDR_WDTH-1:0] in_ref_idx;
    logic [X_CL_WDTH-1:0]     in_x_cl;
    logic [Y_CL_WDTH-1:0]     in_y_cl;
    logic                     in_last_block;
    logic                     in_blk_end;
    logic                     in_luma_en;
    logic                     in_chma_en;
    logic [PAYLOAD_WDTH-1:0]  in_payload;

    modport master (
        output in_valid, in_is_hit, in_set_idx, in_set_addr, in_tag_addr, in_ref_idx,
               in_x_cl, in_y_cl, in_last_block, in_blk_end, in_luma_en, in_chma_en, in_payload,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_is_hit, in_set_idx, in_set_addr, in_tag_addr, in_ref_idx,
               in_x_cl, in_y_cl, in_last_block, in_blk_end, in_luma_en, in_chma_en, in_payload,
        output in_ready
    );
endinterface

// File: rtl/ref_miss_merge_table.sv
// rtl/ref_miss_merge_table.sv - FIFO-ordered CAM of outstanding AR requests for miss merging
module ref_miss_merge_table #(
    parameter int DEPTH  = 4,
    parameter int REF_W  = 4,
    parameter int SET_W  = 5,
    parameter int TAG_W  = 10,
    parameter int CW     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [REF_W-1:0] q_ref,
    input  logic [SET_W-1:0] q_set,
    input  logic [TAG_W-1:0] q_tag,
    output logic             match,
    output logic [CW-1:0]    count,
    output logic             full
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [REF_W-1:0] e_ref [DEPTH];
    logic [SET_W-1:0] e_set [DEPTH];
    logic [TAG_W-1:0] e_tag [DEPTH];
    logic [DEPTH-1:0] e_vld;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count == CW'(DEPTH));
    // A pop on an empty table is a stray fill and is dropped
    assign pop_ok  = pop && (count != '0);
    // A full table still accepts a push when the oldest entry leaves in the same cycle
    assign push_ok = push && (!full || pop_ok);

    // Parallel search of all live entries
    always_comb begin
        match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (e_vld[i] && e_ref[i] == q_ref && e_set[i] == q_set && e_tag[i] == q_tag)
                match = 1'b1;
        end
    end

    // Circular buffer: pop retires the oldest slot, push fills the newest
    always_ff @(posedge clk) begin
        if (reset) begin
            e_vld  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop_ok) begin
                e_vld[rd_ptr] <= 1'b0;
                rd_ptr        <= ptr_inc(rd_ptr);
            end
            if (push_ok) begin
                e_vld[wr_ptr] <= 1'b1;
                e_ref[wr_ptr] <= q_ref;
                e_set[wr_ptr] <= q_set;
                e_tag[wr_ptr] <= q_tag;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (push_ok && !pop_ok)
                count <= count + 1'b1;
            else if (pop_ok && !push_ok)
                count <= count - 1'b1;
        end
    end
endmodule

// File: rtl/ref_tag_compare_pipe.sv
// rtl/ref_tag_compare_pipe.sv - tag-compare stage routing hits/misses to FIFOs; REF_TAG_MISS_MERGE_EN enables miss merging
module ref_tag_compare_pipe #(
    parameter int SET_ADDR_WDTH      = ref_cache_pkg::SET_ADDR_WDTH,
    parameter int TAG_ADDR_WDTH      = ref_cache_pkg::TAG_ADDR_WDTH,
    parameter int C_N_WAY            = ref_cache_pkg::C_N_WAY,
    parameter int REF_ADDR_WDTH      = ref_cache_pkg::REF_ADDR_WDTH,
    parameter int X_CL_WDTH          = 9,
    parameter int Y_CL_WDTH          = 9,
    parameter int BU_X_BITS          = 3,
    parameter int BU_Y_BITS          = 3,
    parameter int AXI_ADDR_WDTH      = 32,
    parameter int BU_OFFSET          = ref_cache_pkg::BU_OFFSET,
    parameter int BU_ROW_OFFSET      = ref_cache_pkg::BU_ROW_OFFSET,
    parameter int IU_OFFSET          = ref_cache_pkg::IU_OFFSET,
    parameter int IU_ROW_OFFSET      = ref_cache_pkg::IU_ROW_OFFSET,
    parameter int FRAME_OFFSET       = ref_cache_pkg::FRAME_OFFSET,
    parameter int PAYLOAD_WDTH       = 64,
    parameter int BLOCK_NUMBER_WIDTH = 6,
    parameter int MERGE_DEPTH        = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    ref_tag_compare_pipe_if.slave         lk,
    input  logic                          miss_full,
    input  logic                          ar_full,
    input  logic                          hit_full,
    input  logic                          op_full,
    input  logic                          fill_done,
    output logic                          hit_wr_en,
    output logic                          miss_wr_en,
    output logic                          ar_valid,
    output logic [AXI_ADDR_WDTH-1:0]      ar_addr,
    output logic                          out_is_hit,
    output logic [C_N_WAY-1:0]            out_set_idx,
    output logic [SET_ADDR_WDTH-1:0]      out_set_addr,
    output logic [TAG_ADDR_WDTH-1:0]      out_tag_addr,
    output logic                          out_last_block,
    output logic                          out_luma_en,
    output logic                          out_chma_en,
    output logic [PAYLOAD_WDTH-1:0]       out_payload,
    output logic                          out_merged,
    output logic [BLOCK_NUMBER_WIDTH-1:0] out_block_number
);
    localparam logic [AXI_ADDR_WDTH-1:0] K_BU  = AXI_ADDR_WDTH'(BU_OFFSET);
    localparam logic [AXI_ADDR_WDTH-1:0] K_BUR = AXI_ADDR_WDTH'(BU_ROW_OFFSET);
    localparam logic [AXI_ADDR_WDTH-1:0] K_IU  = AXI_ADDR_WDTH'(IU_OFFSET);
    localparam logic [AXI_ADDR_WDTH-1:0] K_IUR = AXI_ADDR_WDTH'(IU_ROW_OFFSET);
    localparam logic [AXI_ADDR_WDTH-1:0] K_FR  = AXI_ADDR_WDTH'(FRAME_OFFSET);

    logic                          ready_q;
    logic                          accept;
    logic                          miss_acc;
    logic                          tbl_full;
    logic                          tbl_match;
    logic [BLOCK_NUMBER_WIDTH-1:0] cnt;
    logic [AXI_ADDR_WDTH-1:0]      bux, buy, iux, iuy, refx, addr_nxt;

    assign lk.in_ready = ready_q;
    assign accept      = lk.in_valid & ready_q;
    assign miss_acc    = accept & ~lk.in_is_hit;

    // Line address: block-unit offset inside the CTB plus CTB and frame strides
    assign bux      = AXI_ADDR_WDTH'(lk.in_x_cl[BU_X_BITS-1:0]);
    assign iux      = AXI_ADDR_WDTH'(lk.in_x_cl >> BU_X_BITS);
    assign buy      = AXI_ADDR_WDTH'(lk.in_y_cl[BU_Y_BITS-1:0]);
    assign iuy      = AXI_ADDR_WDTH'(lk.in_y_cl >> BU_Y_BITS);
    assign refx     = AXI_ADDR_WDTH'(lk.in_ref_idx);
    assign addr_nxt = bux * K_BU + buy * K_BUR + iux * K_IU + iuy * K_IUR + refx * K_FR;

`ifdef REF_TAG_MISS_MERGE_EN
    logic [$clog2(MERGE_DEPTH+1)-1:0] unused_tbl_count;

    ref_miss_merge_table #(
        .DEPTH (MERGE_DEPTH),
        .REF_W (REF_ADDR_WDTH),
        .SET_W (SET_ADDR_WDTH),
        .TAG_W (TAG_ADDR_WDTH)
    ) u_tbl (
        .clk   (clk),
        .reset (reset),
        .push  (miss_acc & ~tbl_match),
        .pop   (fill_done),
        .q_ref (lk.in_ref_idx),
        .q_set (lk.in_set_addr),
        .q_tag (lk.in_tag_addr),
        .match (tbl_match),
        .count (unused_tbl_count),
        .full  (tbl_full)
    );
`else
    logic unused_fill_done;
    assign unused_fill_done = fill_done;
    assign tbl_match        = 1'b0;
    assign tbl_full         = 1'b0;
`endif

    // Registered ready: backpressure from any downstream FIFO or the merge table
    always_ff @(posedge clk) begin
        if (reset)
            ready_q <= 1'b0;
        else
            ready_q <= ~(miss_full | ar_full | hit_full | op_full | tbl_full);
    end

    // One-cycle push strobes; zero on every cycle without an accept
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_wr_en  <= 1'b0;
            miss_wr_en <= 1'b0;
            ar_valid   <= 1'b0;
            out_merged <= 1'b0;
        end else begin
            hit_wr_en  <= accept & lk.in_is_hit;
            miss_wr_en <= miss_acc;
            ar_valid   <= miss_acc & ~tbl_match;
            out_merged <= miss_acc & tbl_match;
        end
    end

    // Data outputs and block counter load on accept and hold otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_addr          <= '0;
            out_is_hit       <= 1'b0;
            out_set_idx      <= '0;
            out_set_addr     <= '0;
            out_tag_addr     <= '0;
            out_last_block   <= 1'b0;
            out_luma_en      <= 1'b0;
            out_chma_en      <= 1'b0;
            out_payload      <= '0;
            out_block_number <= '0;
            cnt              <= '0;
        end else if (accept) begin
            ar_addr          <= addr_nxt;
            out_is_hit       <= lk.in_is_hit;
            out_set_idx      <= lk.in_set_idx;
            out_set_addr     <= lk.in_set_addr;
            out_tag_addr     <= lk.in_tag_addr;
            out_last_block   <= lk.in_last_block;
            out_luma_en      <= lk.in_luma_en;
            out_chma_en      <= lk.in_chma_en;
            out_payload      <= lk.in_payload;
            out_block_number <= cnt;
            if (lk.in_blk_end)
                cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_ref_tag_compare_pipe.sv
// tb/tb_ref_tag_compare_pipe.sv - directed vector bench for ref_tag_compare_pipe
module tb_ref_tag_compare_pipe;

    logic        clk = 1'b0;
    logic        reset;
    logic        miss_full, ar_full, hit_full, op_full, fill_done;
    logic        hit_wr_en, miss_wr_en, ar_valid;
    logic [31:0] ar_addr;
    logic        out_is_hit, out_last_block, out_luma_en, out_chma_en, out_merged;
    logic [3:0]  out_set_idx;
    logic [4:0]  out_set_addr;
    logic [9:0]  out_tag_addr;
    logic [63:0] out_payload;
    logic [5:0]  out_block_number;

    int n_chk  = 0;
    int n_fail = 0;

    ref_tag_compare_pipe_if bus ();

    ref_tag_compare_pipe dut (
        .clk              (clk),
        .reset            (reset),
        .lk               (bus),
        .miss_full        (miss_full),
        .ar_full          (ar_full),
        .hit_full         (hit_full),
        .op_full          (op_full),
        .fill_done        (fill_done),
        .hit_wr_en        (hit_wr_en),
        .miss_wr_en       (miss_wr_en),
        .ar_valid         (ar_valid),
        .ar_addr          (ar_addr),
        .out_is_hit       (out_is_hit),
        .out_set_idx      (out_set_idx),
        .out_set_addr     (out_set_addr),
        .out_tag_addr     (out_tag_addr),
        .out_last_block   (out_last_block),
        .out_luma_en      (out_luma_en),
        .out_chma_en      (out_chma_en),
        .out_payload      (out_payload),
        .out_merged       (out_merged),
        .out_block_number (out_block_number)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_hit;
        logic [8:0]  x;
        logic [8:0]  y;
        logic [3:0]  rf;
        logic [4:0]  set;
        logic [9:0]  tag;
        logic        blk;
        logic [63:0] pay;
        logic        e_hit;
        logic        e_miss;
        logic        e_ar;
        logic [31:0] e_addr;
        logic [5:0]  e_bn;
    } vec_t;

    vec_t vt [6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic hit, input logic [8:0] x, input logic [8:0] y, input logic [3:0] rf,
                         input logic [4:0] set, input logic [9:0] tag, input logic blk, input logic [63:0] pay);
        bus.in_valid      = 1'b1;
        bus.in_is_hit     = hit;
        bus.in_set_idx    = 4'b0010;
        bus.in_set_addr   = set;
        bus.in_tag_addr   = tag;
        bus.in_ref_idx    = rf;
        bus.in_x_cl       = x;
        bus.in_y_cl       = y;
        bus.in_last_block = blk;
        bus.in_blk_end    = blk;
        bus.in_luma_en    = 1'b1;
        bus.in_chma_en    = 1'b0;
        bus.in_payload    = pay;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic rdy;
        int   nstb;

        reset = 1'b1;
        {miss_full, ar_full, hit_full, op_full, fill_done} = '0;
        drive(1'b0, 9'd0, 9'd0, 4'd0, 5'd0, 10'd0, 1'b0, 64'd0);
        bus.in_valid = 1'b0;

        vt[0] = '{1'b0, 9'd9,   9'd2,   4'd1,  5'd1,  10'd5,  1'b0, 64'h11,                 1'b0, 1'b1, 1'b1, 32'd4199488,  6'd0};
        vt[1] = '{1'b1, 9'd0,   9'd0,   4'd0,  5'd3,  10'd7,  1'b1, 64'h22,                 1'b1, 1'b0, 1'b0, 32'd0,        6'd0};
        vt[2] = '{1'b0, 9'd511, 9'd511, 4'd15, 5'd2,  10'd9,  1'b1, 64'hDEAD_BEEF_0000_0033, 1'b0, 1'b1, 1'b1, 32'd71434176, 6'd1};
        vt[3] = '{1'b1, 9'd8,   9'd8,   4'd0,  5'd4,  10'd7,  1'b0, 64'h44,                 1'b1, 1'b0, 1'b0, 32'd135168,   6'd2};
        vt[4] = '{1'b0, 9'd3,   9'd9,   4'd2,  5'd6,  10'd11, 1'b1, 64'h55,                 1'b0, 1'b1, 1'b1, 32'd8520384,  6'd2};
        vt[5] = '{1'b1, 9'd0,   9'd0,   4'd0,  5'd31, 10'd1,  1'b1, 64'h66,                 1'b1, 1'b0, 1'b0, 32'd0,        6'd3};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_strobes", {hit_wr_en, miss_wr_en, ar_valid, out_merged}, 0);
        chk("rst_ar_addr", ar_addr, 0);
        chk("rst_block_number", out_block_number, 0);
        chk("rst_payload", out_payload, 0);
        reset = 1'b0;
        step();
        chk("ready_after_reset", bus.in_ready, 1);

        // Table-driven back-to-back vectors
        for (int i = 0; i < 6; i++) begin
            drive(vt[i].is_hit, vt[i].x, vt[i].y, vt[i].rf, vt[i].set, vt[i].tag, vt[i].blk, vt[i].pay);
            step();
            bus.in_valid = 1'b0;
            chk($sformatf("v%0d_hit_wr_en", i), hit_wr_en, vt[i].e_hit);
            chk($sformatf("v%0d_miss_wr_en", i), miss_wr_en, vt[i].e_miss);
            chk($sformatf("v%0d_ar_valid", i), ar_valid, vt[i].e_ar);
            chk($sformatf("v%0d_ar_addr", i), ar_addr, vt[i].e_addr);
            chk($sformatf("v%0d_set_addr", i), out_set_addr, vt[i].set);
            chk($sformatf("v%0d_tag_addr", i), out_tag_addr, vt[i].tag);
            chk($sformatf("v%0d_is_hit", i), out_is_hit, vt[i].is_hit);
            chk($sformatf("v%0d_payload", i), out_payload, vt[i].pay);
            chk($sformatf("v%0d_block_number", i), out_block_number, vt[i].e_bn);
            chk($sformatf("v%0d_merged", i), out_merged, 0);
        end
        chk("v_set_idx", out_set_idx, 4'b0010);
        chk("v_luma_chma", {out_luma_en, out_chma_en, out_last_block}, 3'b101);

        // Idle cycle: strobes drop, data holds
        step();
        chk("idle_strobes", {hit_wr_en, miss_wr_en, ar_valid}, 0);
        chk("idle_set_addr_hold", out_set_addr, 5'd31);
        chk("idle_payload_hold", out_payload, 64'h66);

        // Backpressure from hit_full with a held request
        hit_full = 1'b1;
        step();
        chk("bp_in_ready_low", bus.in_ready, 0);
        drive(1'b1, 9'd1, 9'd1, 4'd0, 5'd12, 10'd3, 1'b0, 64'h77);
        nstb = 0;
        repeat (5) begin
            step();
            nstb += int'(hit_wr_en) + int'(miss_wr_en) + int'(ar_valid);
        end
        chk("bp_no_strobes", nstb, 0);
        hit_full = 1'b0;
        nstb     = 0;
        for (int c = 0; c < 6; c++) begin
            rdy = bus.in_ready;
            step();
            if (rdy)
                bus.in_valid = 1'b0;
            nstb += int'(hit_wr_en);
        end
        chk("bp_one_hit_after_release", nstb, 1);
        chk("bp_set_addr", out_set_addr, 5'd12);

        // Block counter wrap after 64 blk_end accepts
        do_reset();
        drive(1'b1, 9'd0, 9'd0, 4'd0, 5'd1, 10'd1, 1'b1, 64'd0);
        for (int k = 0; k < 65; k++) begin
            step();
            if (k == 63)
                chk("bn_63", out_block_number, 6'd63);
            if (k == 64) begin
                chk("bn_wrap", out_block_number, 6'd0);
                chk("bn_wrap_hit", hit_wr_en, 1);
            end
        end
        bus.in_valid = 1'b0;

        // Duplicate misses back to back
        do_reset();
        drive(1'b0, 9'd4, 9'd4, 4'd3, 5'd7, 10'd100, 1'b0, 64'd1);
        step();
        chk("dup1_ar_valid", ar_valid, 1);
        chk("dup1_merged", out_merged, 0);
        step();
        bus.in_valid = 1'b0;
        chk("dup2_miss_wr_en", miss_wr_en, 1);
`ifdef REF_TAG_MISS_MERGE_EN
        chk("dup2_ar_valid", ar_valid, 0);
        chk("dup2_merged", out_merged, 1);
        for (int m = 0; m < 3; m++) begin
            drive(1'b0, 9'd4, 9'd4, 4'd3, 5'd8 + 5'(m), 10'd100, 1'b0, 64'd2);
            step();
            chk($sformatf("distinct%0d_ar_valid", m), ar_valid, 1);
        end
        bus.in_valid = 1'b0;
        step();
        chk("tbl_full_ready_low", bus.in_ready, 0);
        step();
        chk("tbl_full_ready_held", bus.in_ready, 0);
        fill_done = 1'b1;
        step();
        fill_done = 1'b0;
        chk("tbl_count_after_pop", dut.u_tbl.count, 3);
        step();
        chk("tbl_ready_after_fill", bus.in_ready, 1);
`else
        chk("dup2_ar_valid", ar_valid, 1);
        chk("dup2_merged", out_merged, 0);
`endif

        // Reset in the cycle after a miss accept
        do_reset();
        drive(1'b0, 9'd9, 9'd2, 4'd1, 5'd9, 10'd9, 1'b0, 64'h99);
        step();
        chk("prerst_miss_wr_en", miss_wr_en, 1);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        step();
        chk("midrst_strobes", {hit_wr_en, miss_wr_en, ar_valid, out_merged}, 0);
        chk("midrst_ar_addr", ar_addr, 0);
        chk("midrst_set_addr", out_set_addr, 0);
        chk("midrst_in_ready", bus.in_ready, 0);
`ifdef REF_TAG_MISS_MERGE_EN
        chk("midrst_tbl_count", dut.u_tbl.count, 0);
`endif
        reset = 1'b0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
